// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial nbits-wide adder, LSB first, with val/rdy operand and result handshakes
// One full-adder slice (two half-adder cells plus an OR) walks the operands one bit per cycle.

module serial_adder_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int nbits = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_a,
  input  logic [nbits-1:0] in_b,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_sum,
  output logic             out_cout
);

  localparam int CW = (nbits > 1) ? $clog2(nbits) : 1;
  localparam logic [CW-1:0] LAST = CW'(nbits - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [nbits-1:0] a_q, a_d;
  logic [nbits-1:0] b_q, b_d;
  logic [nbits-1:0] sum_q, sum_d;
  logic [nbits-1:0] msb_v;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic ha0_s, ha0_c, ha1_c, sum_bit, carry_bit;

  serial_adder_ha u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .s_o(ha0_s),   .c_o(ha0_c));
  serial_adder_ha u_ha1 (.a_i(ha0_s),  .b_i(carry_q), .s_o(sum_bit), .c_o(ha1_c));
  assign carry_bit = ha0_c | ha1_c;

  always_comb begin
    state_d          = state_q;
    a_d              = a_q;
    b_d              = b_q;
    sum_d            = sum_q;
    carry_d          = carry_q;
    cnt_d            = cnt_q;
    msb_v            = '0;
    msb_v[nbits-1]   = sum_bit;
    case (state_q)
      IDLE: begin
        if (in_val && in_rdy) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Result fills from the top so bit 0 lands at position 0 after nbits shifts.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = (sum_q >> 1) | msb_v;
        carry_d = carry_bit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign in_rdy   = (state_q == IDLE) && !reset;
  assign out_val  = (state_q == DONE) && !reset;
  assign out_sum  = sum_q;
  assign out_cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder with nbits=4

module tb_serial_adder;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in_a;
  logic [NB-1:0] in_b;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out_sum;
  logic          out_cout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int a;
    int b;
    int exp_sum;
    int exp_cout;
  } vec_t;

  vec_t vecs[6];
  int   exp_q[$];

  serial_adder #(.nbits(NB)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .out_val(out_val), .out_rdy(out_rdy), .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Runs one operation from IDLE; returns the result, ticks from accept to out_val, and total cycles to IDLE.
  task automatic do_op(input int a, input int b, input int stall,
                       output int sum, output int cout, output int lat, output int cycles);
    out_rdy = (stall == 0);
    in_a    = NB'(a);
    in_b    = NB'(b);
    in_val  = 1'b1;
    tick();
    in_val  = 1'b0;
    cycles  = 1;
    lat     = 0;
    while (!out_val && lat < 20) begin
      tick();
      lat++;
    end
    cycles += lat;
    sum  = int'(out_sum);
    cout = int'(out_cout);
    for (int i = 0; i < stall; i++) begin
      tick();
      cycles++;
      check("stall_val", int'(out_val), 1);
      check("stall_sum", int'(out_sum), sum);
      check("stall_rdy", int'(in_rdy), 0);
    end
    out_rdy = 1'b1;
    tick();
    cycles++;
    out_rdy = 1'b0;
    check("ret_idle", int'({out_val, in_rdy}), 1);
  endtask

  initial begin
    int s, c, lat, cyc;

    vecs[0] = '{3, 5, 8, 0};
    vecs[1] = '{15, 1, 0, 1};
    vecs[2] = '{15, 15, 14, 1};
    vecs[3] = '{0, 0, 0, 0};
    vecs[4] = '{6, 9, 15, 0};
    vecs[5] = '{8, 8, 0, 1};

    reset = 1'b1; in_val = 1'b0; in_a = '0; in_b = '0; out_rdy = 1'b0;
    tick();
    check("rst_in_rdy", int'(in_rdy), 0);
    check("rst_out_val", int'(out_val), 0);
    check("rst_sum", int'({out_cout, out_sum}), 0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", int'(in_rdy), 1);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, 0, s, c, lat, cyc);
      check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), c, vecs[i].exp_cout);
      check($sformatf("vec%0d_lat", i), lat, NB);
    end

    // Backpressure: result held for 7 stalled cycles
    do_op(6, 9, 7, s, c, lat, cyc);
    check("bp_sum", s, 15);
    check("bp_cycles", cyc, NB + 2 + 7);

    // Busy-ignore: 7+7 offered throughout the calculation
    in_a = 4'd2; in_b = 4'd2; in_val = 1'b1; out_rdy = 1'b0;
    tick();
    in_a = 4'd7; in_b = 4'd7;
    lat = 0;
    while (!out_val && lat < 20) begin
      check("busy_rdy", int'(in_rdy), 0);
      tick();
      lat++;
    end
    check("busy_lat", lat, NB);
    check("busy_sum", int'({out_cout, out_sum}), 4);
    in_val = 1'b0; out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    for (int i = 0; i < NB + 2; i++) begin
      check("busy_no_extra", int'(out_val), 0);
      tick();
    end

    // Reset on the second CALC cycle aborts the operation
    in_a = 4'd10; in_b = 4'd10; in_val = 1'b1; out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_val", int'(out_val), 0);
    check("abort_rdy", int'(in_rdy), 1);
    for (int i = 0; i < NB + 2; i++) begin
      tick();
      check("abort_no_partial", int'(out_val), 0);
    end
    do_op(1, 1, 0, s, c, lat, cyc);
    check("after_abort_sum", s, 2);
    check("after_abort_cout", c, 0);

    // Exhaustive sweep, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(a, b, 0, s, c, lat, cyc);
        check($sformatf("sweep_%0d_%0d", a, b), c * 16 + s, a + b);
        check("sweep_cycles", cyc, NB + 2);
      end
    end

    // Random traffic against a queue model of accepted operations
    for (int i = 0; i < 600; i++) begin
      in_val  = 1'($urandom_range(0, 1));
      in_a    = 4'($urandom_range(0, 15));
      in_b    = 4'($urandom_range(0, 15));
      out_rdy = ($urandom_range(0, 3) != 0);
      if (in_val && in_rdy) exp_q.push_back(int'(in_a) + int'(in_b));
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) check("rnd_spurious", 1, 0);
        else check("rnd_result", int'({out_cout, out_sum}), exp_q.pop_front());
      end
      tick();
    end
    in_val = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      if (out_val) check("rnd_drain", int'({out_cout, out_sum}), exp_q.pop_front());
      tick();
    end
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial nbits-wide adder; the stage directly downstream of the half-adder cell.
- Datapath is one full-adder slice built from two half-adder cells plus an OR for carry-out, and a carry flip-flop.
- Adds one bit per cycle, LSB first.
- Operand input and result output use val/rdy handshakes, so the block drops into latency-insensitive arithmetic pipelines.

Parameters:
- nbits, 4, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_val  input  1  operand message valid
- in_rdy  output  1  block ready to accept operands
- in_a  input  nbits  operand A
- in_b  input  nbits  operand B
- out_val  output  1  result valid
- out_rdy  input  1  consumer ready for result
- out_sum  output  nbits  A+B modulo 2^nbits
- out_cout  output  1  carry out of bit nbits-1

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - While reset is high and on the cycle it is sampled: state=IDLE, counter=0, carry=0, operand and result registers=0.
  - in_rdy=0 and out_val=0 while reset is high; in_rdy=1 from the first cycle after reset deasserts.
- States are IDLE, CALC, DONE; outputs are Moore-style, derived from state only.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val&in_rdy: latch in_a and in_b into shift registers, clear carry and counter, go to CALC.
- CALC:
  - in_rdy=0, out_val=0.
  - Each cycle: sum_bit = a[0]^b[0]^carry; carry <= majority(a[0],b[0],carry).
  - Shift A and B right by 1.
  - Shift sum_bit into the result register MSB, so the result shifts right.
  - counter increments; when counter==nbits-1 (the last bit is being processed), go to DONE.
  - CALC lasts exactly nbits cycles.
- DONE:
  - out_val=1; out_sum holds the full sum; out_cout holds the final carry; in_rdy=0.
  - On out_val&out_rdy go to IDLE.
  - out_sum and out_cout stay stable until the handshake; they are not cleared after it.
- Latency: an operand accepted on edge k gives out_val=1 in the cycle after edge k+nbits, i.e. nbits+1 cycles after the input handshake.
- Throughput: one operation per nbits+2 cycles minimum; there is no overlap of DONE and IDLE.
- Boundary conditions:
  - in_val while in CALC or DONE is ignored; the operands are neither latched nor queued.
  - out_rdy held low in DONE: the block stalls indefinitely with the outputs stable.
  - out_rdy high outside DONE has no effect.
  - Reset asserted in CALC or DONE aborts the operation. The next cycle is IDLE, out_val=0, and no partial result is ever presented.
  - nbits=1: CALC lasts exactly one cycle.
  - Overflow wraps modulo 2^nbits, with the lost bit reported on out_cout.
- No combinational path from in_val or out_rdy to in_rdy or out_val.

Test Plan (nbits=4):
- Basic add: in_a=3, in_b=5, out_rdy=1 -> out_val rises 5 cycles after accept; out_sum=8, out_cout=0; in_rdy=1 the next cycle.
- Carry ripple and overflow:
  - 15+1 -> out_sum=0, out_cout=1.
  - 15+15 -> out_sum=14, out_cout=1.
  - 0+0 -> out_sum=0, out_cout=0.
- Backpressure: 6+9 with out_rdy=0 for 7 cycles after out_val -> out_val=1 and out_sum=15 held stable throughout; in_rdy=0 throughout. Raise out_rdy -> IDLE the next cycle.
- Busy-ignore: accept 2+2, then drive in_val=1 with in_a=7, in_b=7 during CALC -> result out_sum=4, out_cout=0; the 7+7 operands are never consumed.
- Reset mid-operation: accept 10+10, assert reset on the 2nd CALC cycle -> the next cycle out_val=0 and in_rdy=1. A following 1+1 gives out_sum=2, out_cout=0 (carry cleared).
- Exhaustive sweep: all 256 (a,b) pairs back-to-back with out_rdy=1 -> every result equals {cout,sum} = a+b; each operation occupies exactly 6 cycles from accept to return to IDLE.
